// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the blocks that drive it.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rez_t;
    } instruction_t;

endpackage

// File: rtl/instr_register_sched_if.sv
// Bundle between the requesters, the instruction register and the scheduler.
// master = scheduler side, slave = requesters plus register side.
interface instr_register_sched_if;
    import instr_register_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    opcode_t  [1:0]     req_opcode;
    operand_t [1:0]     req_operand_a;
    operand_t [1:0]     req_operand_b;

    logic               load_en;
    address_t           write_pointer;
    opcode_t            opcode;
    operand_t           operand_a;
    operand_t           operand_b;

    address_t           read_pointer;
    instruction_t       instruction_word;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    instruction_t       rsp_word;

    modport master (
        input  req_valid, req_opcode, req_operand_a, req_operand_b,
        input  instruction_word, rsp_ready,
        output req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
        output read_pointer, rsp_valid, rsp_id, rsp_word
    );

    modport slave (
        output req_valid, req_opcode, req_operand_a, req_operand_b,
        output instruction_word, rsp_ready,
        input  req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
        input  read_pointer, rsp_valid, rsp_id, rsp_word
    );

endinterface

// File: rtl/instr_register_sched.sv
// Shares one instruction register between two requesters; INSTR_REG_SCHED_FIXED_PRIO_EN makes requester 0 win ties.
// Latency: load_en the cycle after a request handshake, rsp_valid three cycles after load_en on an empty pipeline.
// Backpressure: req_ready drops when all DEPTH slots are allocated; rsp_valid holds stable until rsp_ready.
module instr_register_sched
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_register_sched_if.master bus
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_FETCH = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]  alloc_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    alloc_cnt;
    logic [DEPTH-1:0] written;
    logic [DEPTH-1:0] owner;
    logic [1:0]     state;

    logic [1:0]     grant;
    logic [1:0]     ready;
    logic           not_full;
    logic           hs;
    logic           hs_id;
    logic           rsp_done;

    logic           load_en_q;
    logic [AW-1:0]  wr_ptr_q;
    opcode_t        opcode_q;
    operand_t       opa_q;
    operand_t       opb_q;
    instruction_t   rsp_word_q;
    logic           rsp_id_q;

`ifndef INSTR_REG_SCHED_FIXED_PRIO_EN
    logic           last_grant;
`endif

    always_comb begin
        grant = 2'b00;
        case (bus.req_valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef INSTR_REG_SCHED_FIXED_PRIO_EN
                grant = 2'b01;
`else
                grant = last_grant ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

    // grant is only ever non-zero for a valid requester, so any ready bit is a handshake
    assign not_full = (alloc_cnt < CNT_FULL);
    assign ready    = not_full ? grant : 2'b00;
    assign hs       = |ready;
    assign hs_id    = ready[1];
    assign rsp_done = (state == ST_RESP) && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr  <= '0;
            rd_ptr     <= '0;
            alloc_cnt  <= '0;
            written    <= '0;
            owner      <= '0;
            state      <= ST_IDLE;
            load_en_q  <= 1'b0;
            wr_ptr_q   <= '0;
            opcode_q   <= ZERO;
            opa_q      <= '0;
            opb_q      <= '0;
            rsp_word_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            load_en_q <= hs;
            if (hs) begin
                alloc_ptr        <= alloc_ptr + 1'b1;
                owner[alloc_ptr] <= hs_id;
                wr_ptr_q         <= alloc_ptr;
                opcode_q         <= bus.req_opcode[hs_id];
                opa_q            <= bus.req_operand_a[hs_id];
                opb_q            <= bus.req_operand_b[hs_id];
            end

            case ({hs, rsp_done})
                2'b10:   alloc_cnt <= alloc_cnt + 1'b1;
                2'b01:   alloc_cnt <= alloc_cnt - 1'b1;
                default: alloc_cnt <= alloc_cnt;
            endcase

            // the slot being read is never the slot being committed, so the two updates cannot collide
            if (rsp_done)
                written[rd_ptr] <= 1'b0;
            if (load_en_q)
                written[wr_ptr_q] <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (written[rd_ptr])
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    rsp_word_q <= bus.instruction_word;
                    rsp_id_q   <= owner[rd_ptr];
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef INSTR_REG_SCHED_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (hs)
            last_grant <= hs_id;
    end
`endif

    assign bus.req_ready     = ready;
    assign bus.load_en       = load_en_q;
    assign bus.write_pointer = wr_ptr_q;
    assign bus.opcode        = opcode_q;
    assign bus.operand_a     = opa_q;
    assign bus.operand_b     = opb_q;
    assign bus.read_pointer  = rd_ptr;
    assign bus.rsp_valid     = (state == ST_RESP);
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_word      = rsp_word_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ready));
    a_cnt_bound:    assert property (@(posedge clk) disable iff (reset) alloc_cnt <= CNT_FULL);
    a_rsp_hold:     assert property (@(posedge clk) disable iff (reset)
                        (state == ST_RESP && !bus.rsp_ready) |=>
                        (state == ST_RESP && $stable(rsp_word_q) && $stable(rsp_id_q)));

endmodule

// File: tb/tb_instr_register_sched.sv
// Bench for instr_register_sched with a behavioural instruction register on the slave side.
`timescale 1ns/1ps
module tb_instr_register_sched;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_register_sched_if bus();

    instr_register_sched #(.DEPTH(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction register: stores the request and computes its result at load time
    instruction_t mem [32];

    function automatic result_t calc(input opcode_t o, input operand_t a, input operand_t b);
        case (o)
            PASSA:   return result_t'(a);
            PASSB:   return result_t'(b);
            ADD:     return result_t'(a) + result_t'(b);
            SUB:     return result_t'(a) - result_t'(b);
            MULT:    return result_t'(a) * result_t'(b);
            DIV:     return (b == 0) ? result_t'(0) : result_t'(a) / result_t'(b);
            MOD:     return (b == 0) ? result_t'(0) : result_t'(a) % result_t'(b);
            default: return result_t'(0);
        endcase
    endfunction

    initial for (int i = 0; i < 32; i++) mem[i] = '0;

    always @(posedge clk)
        if (bus.load_en)
            mem[bus.write_pointer] <= '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b,
                                        rez_t: calc(bus.opcode, bus.operand_a, bus.operand_b)};

    assign bus.instruction_word = mem[bus.read_pointer];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int      id;
        opcode_t opc;
        int      a;
        int      b;
        longint  rez;
    } vec_t;

    vec_t vecs [8];

    task automatic wait_rsp(input int budget);
        int k = 0;
        while (!bus.rsp_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Single request through write, readback and response; rsp_ready must already be high
    task automatic run_vec(input int i, input int slot);
        vec_t v;
        int   k;
        v = vecs[i];
        bus.req_opcode[v.id]    = v.opc;
        bus.req_operand_a[v.id] = v.a;
        bus.req_operand_b[v.id] = v.b;
        bus.req_valid[v.id]     = 1'b1;
        #1;
        k = 0;
        while (!bus.req_ready[v.id] && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk($sformatf("v%0d_ready", i), 64'(bus.req_ready[v.id]), 64'(1));
        @(negedge clk);
        bus.req_valid[v.id] = 1'b0;
        chk($sformatf("v%0d_load_en", i), 64'(bus.load_en), 64'(1));
        chk($sformatf("v%0d_wp", i), 64'(bus.write_pointer), 64'(slot));
        chk($sformatf("v%0d_opcode", i), 64'(bus.opcode), 64'(v.opc));
        chk($sformatf("v%0d_opa", i), 64'(bus.operand_a), 64'(v.a));
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.rsp_valid && k < 20);
        chk($sformatf("v%0d_latency", i), 64'(k), 64'(3));
        chk($sformatf("v%0d_rsp_id", i), 64'(bus.rsp_id), 64'(v.id));
        chk($sformatf("v%0d_rsp_opc", i), 64'(bus.rsp_word.opc), 64'(v.opc));
        chk($sformatf("v%0d_rsp_rez", i), 64'(bus.rsp_word.rez_t), 64'(v.rez));
        @(negedge clk);
        chk($sformatf("v%0d_rsp_drop", i), 64'(bus.rsp_valid), 64'(0));
    endtask

    // Holds req_valid on one requester until n accepted or the budget runs out; checks each write
    task automatic burst(input int id, input int n, input int budget, output int acc);
        int wr;
        acc = 0;
        wr  = 0;
        bus.req_opcode[id]    = PASSA;
        bus.req_operand_b[id] = '0;
        for (int c = 0; c < budget && wr < n; c++) begin
            @(negedge clk);
            if (bus.load_en) begin
                chk("burst_wp", 64'(bus.write_pointer), 64'(wr % 32));
                chk("burst_opa", 64'(bus.operand_a), 64'(wr));
                wr++;
            end
            if (acc == n) begin
                bus.req_valid[id] = 1'b0;
            end else begin
                bus.req_operand_a[id] = acc;
                bus.req_valid[id]     = 1'b1;
                #1;
                if (bus.req_ready[id]) acc++;
            end
        end
    endtask

    logic [1:0] rst_pat [4];
    logic [1:0] rst_exp [4];
    logic [1:0] tie_ready [4];
    int         tie_a [4];
    int         tie_id [4];
    int         acc;

    initial begin
        vecs[0] = '{0, ADD,   5,  3,   8};
        vecs[1] = '{1, SUB,   10, 4,   6};
        vecs[2] = '{0, MULT,  7,  6,   42};
        vecs[3] = '{1, PASSA, 9,  2,   9};
        vecs[4] = '{0, PASSB, 9,  2,   2};
        vecs[5] = '{1, SUB,   3,  5,   -2};
        vecs[6] = '{0, ZERO,  11, 12,  0};
        vecs[7] = '{1, MULT,  -4, 25,  -100};

        rst_pat = '{2'b01, 2'b10, 2'b11, 2'b00};
        rst_exp = '{2'b01, 2'b10, 2'b01, 2'b00};
`ifdef INSTR_REG_SCHED_FIXED_PRIO_EN
        tie_ready = '{2'b01, 2'b01, 2'b01, 2'b01};
        tie_a     = '{100, 100, 100, 100};
        tie_id    = '{0, 0, 0, 0};
`else
        tie_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        tie_a     = '{100, 200, 100, 200};
        tie_id    = '{0, 1, 0, 1};
`endif

        reset             = 1'b1;
        bus.req_valid     = 2'b00;
        bus.req_opcode[0] = ZERO;
        bus.req_opcode[1] = ZERO;
        bus.req_operand_a = '0;
        bus.req_operand_b = '0;
        bus.rsp_ready     = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_load_en", 64'(bus.load_en), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_read_ptr", 64'(bus.read_pointer), 64'(0));
        chk("rst_write_ptr", 64'(bus.write_pointer), 64'(0));
        chk("rst_opcode", 64'(bus.opcode), 64'(ZERO));
        chk("rst_opa", 64'(bus.operand_a), 64'(0));
        chk("rst_opb", 64'(bus.operand_b), 64'(0));
        chk("rst_rsp_word", 64'(|bus.rsp_word), 64'(0));
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        for (int p = 0; p < 4; p++) begin
            bus.req_valid = rst_pat[p];
            #1;
            chk($sformatf("rst_ready_%0d", p), 64'(bus.req_ready), 64'(rst_exp[p]));
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, i);

        // Tie: both requesters valid for four accepted cycles, responses held back until all written
        do_reset();
        bus.rsp_ready        = 1'b0;
        bus.req_opcode[0]    = PASSA;
        bus.req_opcode[1]    = PASSA;
        bus.req_operand_a[0] = 100;
        bus.req_operand_a[1] = 200;
        bus.req_valid        = 2'b11;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("tie_ready_%0d", c), 64'(bus.req_ready), 64'(tie_ready[c]));
            @(negedge clk);
            chk($sformatf("tie_load_%0d", c), 64'(bus.load_en), 64'(1));
            chk($sformatf("tie_wp_%0d", c), 64'(bus.write_pointer), 64'(c));
            chk($sformatf("tie_opa_%0d", c), 64'(bus.operand_a), 64'(tie_a[c]));
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wait_rsp(20);
            chk($sformatf("tie_rsp_vld_%0d", c), 64'(bus.rsp_valid), 64'(1));
            chk($sformatf("tie_rsp_id_%0d", c), 64'(bus.rsp_id), 64'(tie_id[c]));
            chk($sformatf("tie_rsp_rez_%0d", c), 64'(bus.rsp_word.rez_t), 64'(tie_a[c]));
            @(negedge clk);
        end

        // Fill: 33 requests against a stalled response side
        do_reset();
        bus.rsp_ready = 1'b0;
        burst(0, 33, 40, acc);
        chk("fill_accepted", 64'(acc), 64'(32));
        chk("fill_stall", 64'(bus.req_ready[0]), 64'(0));
        chk("fill_rsp_vld", 64'(bus.rsp_valid), 64'(1));
        chk("fill_rsp_opa", 64'(bus.rsp_word.op_a), 64'(0));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("fill_reopen", 64'(bus.req_ready[0]), 64'(1));
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("fill_33_load", 64'(bus.load_en), 64'(1));
        chk("fill_33_wp", 64'(bus.write_pointer), 64'(0));
        chk("fill_33_opa", 64'(bus.operand_a), 64'(32));

        // Same edge: a grant and a response completion together leave the count unchanged
        wait_rsp(20);
        chk("se_rsp1_opa", 64'(bus.rsp_word.op_a), 64'(1));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        wait_rsp(20);
        chk("se_rsp2_opa", 64'(bus.rsp_word.op_a), 64'(2));
        bus.req_operand_a[0] = 33;
        bus.req_valid[0]     = 1'b1;
        bus.rsp_ready        = 1'b1;
        #1;
        chk("se_ready", 64'(bus.req_ready[0]), 64'(1));
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        bus.rsp_ready    = 1'b0;
        chk("se_cnt", 64'(dut.alloc_cnt), 64'(31));
        chk("se_load", 64'(bus.load_en), 64'(1));
        chk("se_wp", 64'(bus.write_pointer), 64'(1));
        chk("se_rsp_drop", 64'(bus.rsp_valid), 64'(0));
        bus.req_valid[0] = 1'b1;
        #1;
        chk("se_one_more", 64'(bus.req_ready[0]), 64'(1));
        @(negedge clk);
        chk("se_full_again", 64'(bus.req_ready[0]), 64'(0));
        bus.req_valid[0] = 1'b0;

        // Mid-stream reset with five entries outstanding
        do_reset();
        bus.rsp_ready = 1'b0;
        burst(1, 5, 20, acc);
        chk("mr_accepted", 64'(acc), 64'(5));
        wait_rsp(20);
        chk("mr_rsp_vld", 64'(bus.rsp_valid), 64'(1));
        chk("mr_rsp_id", 64'(bus.rsp_id), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("mr_rsp_cleared", 64'(bus.rsp_valid), 64'(0));
        chk("mr_cnt", 64'(dut.alloc_cnt), 64'(0));
        chk("mr_load_en", 64'(bus.load_en), 64'(0));
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("mr_stays_idle", 64'(bus.rsp_valid), 64'(0));
        bus.rsp_ready = 1'b1;
        run_vec(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
